// File: rtl/ebike_a2d_pkg.sv
// Shared types and helpers for the eBike A2D round-robin sequencer.
package ebike_a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      DEAD,
      RD,
      GAP
   } a2d_state_t;

   localparam logic [2:0] CH_BATT   = 3'd0;
   localparam logic [2:0] CH_CURR   = 3'd1;
   localparam logic [2:0] CH_BRAKE  = 3'd3;
   localparam logic [2:0] CH_TORQUE = 3'd4;

   // Result slot order is fixed: batt, curr, brake, torque.
   function automatic logic [2:0] idx_to_ch(input logic [1:0] idx);
      case (idx)
         2'd0:    return CH_BATT;
         2'd1:    return CH_CURR;
         2'd2:    return CH_BRAKE;
         default: return CH_TORQUE;
      endcase
   endfunction

   function automatic logic [15:0] mk_a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_period_tmr.sv
// Free-running round timer; tmr_full marks the last count before wrap.
module a2d_period_tmr #(
   parameter int PERIOD_W = 14
) (
   input  logic clk,
   input  logic rst_n,
   output logic tmr_full
);

   logic [PERIOD_W-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer <= '0;
      else        timer <= timer + 1'b1;
   end

   assign tmr_full = &timer;

endmodule

// File: rtl/a2d_rr_intf.sv
// Round-robin A2D sequencer driving the SPI monarch; define A2D_FILT_EN to
// low-pass each channel result as (3*old + sample) / 4.
module a2d_rr_intf
   import ebike_a2d_pkg::*;
#(
   parameter int PERIOD_W = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        snd,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] resp,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] brake,
   output logic [11:0] torque,
   output logic        rnd_cmplt,
   output logic        busy
);

   a2d_state_t  state, state_nxt;
   logic [1:0]  idx, idx_nxt;
   logic        snd_nxt, cmplt_nxt, cap;
   logic        tmr_full;
   logic [11:0] res [4];
   logic [11:0] sample, cap_val;

   a2d_period_tmr #(.PERIOD_W(PERIOD_W)) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .tmr_full (tmr_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 2'd0;
         snd       <= 1'b0;
         rnd_cmplt <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         snd       <= snd_nxt;
         rnd_cmplt <= cmplt_nxt;
      end
   end

   // snd is registered, so it rises one clk after the deciding state; the
   // DEAD and GAP states therefore leave a full idle clk after each done.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      snd_nxt   = 1'b0;
      cmplt_nxt = 1'b0;
      cap       = 1'b0;
      case (state)
         IDLE: begin
            if (tmr_full) begin
               snd_nxt   = 1'b1;
               idx_nxt   = 2'd0;
               state_nxt = SEL;
            end
         end
         SEL: begin
            if (done) state_nxt = DEAD;
         end
         DEAD: begin
            snd_nxt   = 1'b1;
            state_nxt = RD;
         end
         RD: begin
            if (done) begin
               cap = 1'b1;
               if (idx == 2'd3) begin
                  cmplt_nxt = 1'b1;
                  idx_nxt   = 2'd0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = idx + 2'd1;
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            snd_nxt   = 1'b1;
            state_nxt = SEL;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sample = 12'(resp);

`ifdef A2D_FILT_EN
   logic [13:0] filt_sum;
   assign filt_sum = 14'(res[idx]) * 14'd3 + 14'(sample);
   assign cap_val  = 12'(filt_sum >> 2);
`else
   assign cap_val  = sample;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) res[i] <= 12'h000;
      end else if (cap) begin
         res[idx] <= cap_val;
      end
   end

   assign cmd    = mk_a2d_cmd(idx_to_ch(idx));
   assign busy   = (state != IDLE);
   assign batt   = res[0];
   assign curr   = res[1];
   assign brake  = res[2];
   assign torque = res[3];

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Scoreboard bench for a2d_rr_intf: the stimulus side plays the SPI monarch
// and predicts results, a monitor checks the DUT against the predictions.
module tb_a2d_rr_intf;

   localparam int PW          = 6;
   localparam int PERIOD      = 1 << PW;
   localparam int WAIT_BUDGET = 400;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        done  = 1'b0;
   logic [15:0] resp  = 16'h0000;
   logic        snd;
   logic [15:0] cmd;
   logic [11:0] batt, curr, brake, torque;
   logic        rnd_cmplt, busy;

   typedef struct {
      int          kind;
      int          idx;
      logic [11:0] val;
   } scb_entry_t;

   scb_entry_t  scb [$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc;
   int          chmap [4] = '{0, 1, 3, 4};
   logic [11:0] mdl [4];
   logic [11:0] exp_first [4];
   logic [11:0] exp_const [4];

   bit          pend;
   bit          prev_done;
   bit          exp_cmplt;
   int          round_tx;
   int          exp_start;
   logic [15:0] last_cmd;
   logic [11:0] exp_regs [4];
   scb_entry_t  mon_e;
   bit          ok;

`ifdef A2D_FILT_EN
   initial exp_first = '{12'h048, 12'h049, 12'h049, 12'h049};
   initial exp_const = '{12'h100, 12'h1C0, 12'h250, 12'h2BC};
`else
   initial exp_first = '{12'h123, 12'h124, 12'h126, 12'h127};
   initial exp_const = '{12'h400, 12'h400, 12'h400, 12'h400};
`endif

   a2d_rr_intf #(.PERIOD_W(PW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .snd       (snd),
      .cmd       (cmd),
      .done      (done),
      .resp      (resp),
      .batt      (batt),
      .curr      (curr),
      .brake     (brake),
      .torque    (torque),
      .rnd_cmplt (rnd_cmplt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [11:0] nextVal(input logic [11:0] old, input logic [11:0] s);
      int t;
`ifdef A2D_FILT_EN
      t = (3 * int'(old) + int'(s)) / 4;
`else
      t = int'(s);
`endif
      return t[11:0];
   endfunction

   function automatic logic [11:0] regOf(input int i);
      case (i)
         0:       return batt;
         1:       return curr;
         2:       return brake;
         default: return torque;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic waitSnd(output bit good);
      int k = 0;
      good = 1'b1;
      while (snd !== 1'b1 && k < WAIT_BUDGET) begin
         @(negedge clk);
         k++;
      end
      if (snd !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL snd_timeout: got no snd within %0d clks, expected a snd pulse", WAIT_BUDGET);
         good = 1'b0;
      end
   endtask

   // One SPI transaction: wait for snd, answer after 'delay' clks with one clk of done.
   task automatic applyStimulus(input int kind, input int idx, input logic [11:0] data,
                                input int delay, output bit good);
      scb_entry_t e;
      waitSnd(good);
      if (!good) return;
      repeat (delay) @(negedge clk);
      e.kind = kind;
      e.idx  = idx;
      e.val  = 12'h000;
      if (kind == 1) begin
         mdl[idx] = nextVal(mdl[idx], data);
         e.val    = mdl[idx];
      end
      scb.push_back(e);
      resp = {4'($urandom), data};
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      resp = 16'($urandom);
   endtask

   task automatic serveRound(input int mode, input int dmin, input int dmax, output bit good);
      logic [11:0] data;
      good = 1'b1;
      for (int i = 0; i < 8; i++) begin
         case (mode)
            0:       data = 12'(12'h123 + chmap[i / 2]);
            1:       data = 12'($urandom);
            default: data = 12'h400;
         endcase
         applyStimulus(i % 2, i / 2, data, int'($urandom_range(dmax, dmin)), good);
         if (!good) return;
      end
   endtask

   // done while IDLE must be ignored; kept clear of the next wrap.
   task automatic injectSpurious();
      scb_entry_t e;
      int k = 0;
      while ((busy || (cyc % PERIOD) >= 50) && k < 2 * PERIOD) begin
         @(negedge clk);
         k++;
      end
      if (busy) return;
      e.kind = 2;
      e.idx  = 0;
      e.val  = 12'h000;
      scb.push_back(e);
      resp = 16'($urandom);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   // Monitor: samples shortly after each falling edge.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         pend      = 1'b0;
         prev_done = 1'b0;
         round_tx  = 0;
         exp_start = PERIOD;
         scb.delete();
         for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
      end else begin
         exp_cmplt = 1'b0;
         if (pend) begin
            pend = 1'b0;
            if (scb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL scb_underflow: got a done with no prediction, expected one queued");
            end else begin
               mon_e = scb.pop_front();
               if (mon_e.kind == 1) begin
                  exp_regs[mon_e.idx] = mon_e.val;
                  checkOutput($sformatf("capture_ch%0d", chmap[mon_e.idx]), 32'(regOf(mon_e.idx)), 32'(mon_e.val));
                  if (mon_e.idx == 3) begin
                     exp_cmplt = 1'b1;
                     checkOutput("snd_per_round", round_tx, 8);
                     checkOutput("busy_at_cmplt", 32'(busy), 0);
                     round_tx  = 0;
                     exp_start = (cyc / PERIOD + 1) * PERIOD;
                  end
               end
            end
         end
         checkOutput("rnd_cmplt", 32'(rnd_cmplt), 32'(exp_cmplt));
         if (snd) begin
            checkOutput("cmd", 32'(cmd), 32'({2'b00, 3'(chmap[(round_tx / 2) % 4]), 11'h000}));
            checkOutput("snd_gap_after_done", 32'(prev_done), 0);
            checkOutput("busy_at_snd", 32'(busy), 1);
            if (round_tx == 0) begin
               checkOutput("round_start_cycle", cyc, exp_start);
               for (int i = 0; i < 4; i++)
                  checkOutput($sformatf("hold_ch%0d", chmap[i]), 32'(regOf(i)), 32'(exp_regs[i]));
            end
            last_cmd = cmd;
            round_tx++;
         end
         if (done) begin
            checkOutput("snd_with_done", 32'(snd), 0);
            if (scb.size() > 0 && scb[scb.size() - 1].kind != 2)
               checkOutput("cmd_stable", 32'(cmd), 32'(last_cmd));
            pend = 1'b1;
         end
         prev_done = done;
      end
   end

   initial begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
      repeat (3) @(negedge clk);
      checkOutput("reset_snd", 32'(snd), 0);
      checkOutput("reset_cmd", 32'(cmd), 0);
      checkOutput("reset_batt", 32'(batt), 0);
      checkOutput("reset_torque", 32'(torque), 0);
      checkOutput("reset_rnd_cmplt", 32'(rnd_cmplt), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      rst_n = 1'b1;

      $display("[TB] directed round, response 0x123+ch with junk upper nibble");
      serveRound(0, 40, 40, ok);
      if (ok) begin
         for (int i = 0; i < 4; i++)
            checkOutput($sformatf("first_round_ch%0d", chmap[i]), 32'(regOf(i)), 32'(exp_first[i]));
         injectSpurious();
      end

      $display("[TB] randomized rounds");
      for (int r = 0; r < 6 && ok; r++) begin
         if (r == 2) serveRound(1, 60, 90, ok);
         else        serveRound(1, 2, 50, ok);
         if (ok && r == 3) injectSpurious();
      end

      $display("[TB] reset during a round after curr is updated");
      for (int i = 0; i < 4 && ok; i++)
         applyStimulus(i % 2, i / 2, 12'($urandom), int'($urandom_range(30, 2)), ok);
      if (ok) waitSnd(ok);
      if (ok) begin
         repeat (5) @(negedge clk);
         #3 rst_n = 1'b0;
         #1;
         checkOutput("midreset_snd", 32'(snd), 0);
         checkOutput("midreset_cmd", 32'(cmd), 0);
         checkOutput("midreset_batt", 32'(batt), 0);
         checkOutput("midreset_curr", 32'(curr), 0);
         checkOutput("midreset_brake", 32'(brake), 0);
         checkOutput("midreset_busy", 32'(busy), 0);
         for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end

      $display("[TB] four rounds of constant sample 0x400");
      for (int r = 0; r < 4 && ok; r++) begin
         serveRound(2, 2, 40, ok);
         if (ok) checkOutput($sformatf("const_round%0d_batt", r), 32'(batt), 32'(exp_const[r]));
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
